// File: rtl/dcache_mem_stage_if.sv
// dcache_mem_stage_if
// Backing-memory request/acknowledge bus between the MEM-stage data cache
// (master) and main memory (slave).
//   bus_req   : request held high until the cycle after bus_ack
//   bus_we    : 1 = write, 0 = read; valid while bus_req = 1
//   bus_addr  : word-aligned byte address
//   bus_wdata : store data
//   bus_ack   : one-cycle completion pulse from memory
//   bus_rdata : read data, valid with bus_ack
interface dcache_mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dcache_mem_stage.sv
// dcache_mem_stage
// MEM-stage data cache: direct-mapped, one word per line, write-through,
// no-write-allocate. hit=1 lets the EX/MEM register advance, hit=0 stalls it.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   mem_read         : load request
//   mem_write        : store request (wins when both are set)
//   addr, wdata      : byte address (addr[1:0] ignored), store data
//   rdata, hit       : load data, access complete / no access
//   bus              : backing-memory req/ack bus (master side)
// Optional (define DCACHE_STATS_EN):
//   stat_hits, stat_misses : saturating read-hit / read-miss counters
//
// state | meaning
// IDLE  | lookup; read hits answer in the same cycle
// FETCH | read miss, waiting for bus_ack to fill the line
// WRITE | store written through to memory, waiting for bus_ack
// DONE  | one-cycle completion, hit=1
module dcache_mem_stage #(
  parameter int INDEX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                hit,
  dcache_mem_stage_if.master  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  // High for the single cycle following reset: hit is held at 1 and no
  // request is accepted while the pipeline comes out of reset.
  logic                  rst_hold_q;
  logic                  op_write_q;
  logic [31:0]           capture_q;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [31:0]           bus_addr_q;
  logic [31:0]           bus_wdata_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  lookup_hit;
  logic                  is_read;
  logic                  accept;
  logic                  start_fetch;
  logic                  start_write;
  logic                  fill_en;
  logic                  upd_en;
  logic                  unused_addr;

  assign idx         = addr[INDEX_BITS+1:2];
  assign tag         = addr[31:INDEX_BITS+2];
  assign fill_idx    = bus_addr_q[INDEX_BITS+1:2];
  assign fill_tag    = bus_addr_q[31:INDEX_BITS+2];
  assign unused_addr = ^addr[1:0];

  assign lookup_hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign is_read     = mem_read && !mem_write;
  assign accept      = (state == ST_IDLE) && !rst_hold_q;
  assign start_fetch = accept && is_read && !lookup_hit;
  assign start_write = accept && mem_write;
  assign fill_en     = rst_n && (state == ST_FETCH) && bus.bus_ack;
  assign upd_en      = rst_n && start_write && lookup_hit;

  always_comb begin
    hit   = 1'b0;
    rdata = 32'd0;
    if (!rst_n || rst_hold_q) begin
      hit = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_write) begin
            hit = 1'b0;
          end else if (mem_read) begin
            hit   = lookup_hit;
            rdata = lookup_hit ? data_q[idx] : 32'd0;
          end else begin
            hit = 1'b1;
          end
        end
        ST_DONE: begin
          hit   = 1'b1;
          rdata = op_write_q ? 32'd0 : capture_q;
        end
        default: hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      valid_q     <= '0;
      rst_hold_q  <= 1'b1;
      op_write_q  <= 1'b0;
      capture_q   <= 32'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
    end else begin
      rst_hold_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_write) begin
            state       <= ST_WRITE;
            op_write_q  <= 1'b1;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b1;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_wdata_q <= wdata;
          end else if (start_fetch) begin
            state      <= ST_FETCH;
            op_write_q <= 1'b0;
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= {addr[31:2], 2'b00};
          end
        end
        ST_FETCH: begin
          if (bus.bus_ack) begin
            valid_q[fill_idx] <= 1'b1;
            capture_q         <= bus.bus_rdata;
            bus_req_q         <= 1'b0;
            bus_we_q          <= 1'b0;
            state             <= ST_DONE;
          end
        end
        ST_WRITE: begin
          if (bus.bus_ack) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            state     <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.bus_rdata;
    end else if (upd_en) begin
      data_q[idx] <= wdata;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

`ifdef DCACHE_STATS_EN
  logic read_hit;
  assign read_hit = accept && is_read && lookup_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
    end else begin
      if (read_hit && (stat_hits != 32'hFFFF_FFFF))
        stat_hits <= stat_hits + 32'd1;
      if (start_fetch && (stat_misses != 32'hFFFF_FFFF))
        stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_stage.sv
// tb_dcache_mem_stage
// Directed bench for dcache_mem_stage. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
// Define DCACHE_STATS_EN to also exercise the statistics counters.
module tb_dcache_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int n_checks;
  int n_errors;

  dcache_mem_stage_if bus_if ();

  dcache_mem_stage #(.INDEX_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .hit       (hit),
    .bus       (bus_if.master)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
  endtask

  // Miss path (read miss or any write). ack arrives in FETCH/WRITE cycle
  // number ack_delay (0 = first cycle); DONE cycle is checked last.
  task automatic miss_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_delay, input logic [31:0] brd,
                             input logic [31:0] exp_rdata);
    @(negedge clk);
    drive(rd, wr, a, wd);
    #1;
    check_val({tag, "_req_hit"}, {31'd0, hit}, 32'd0);
    for (int k = 0; k <= ack_delay; k++) begin
      @(negedge clk);
      if (k == ack_delay) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = brd;
      end
      #1;
      check_val({tag, "_bus_req"}, {31'd0, bus_if.bus_req}, 32'd1);
      check_val({tag, "_bus_we"}, {31'd0, bus_if.bus_we}, {31'd0, wr});
      check_val({tag, "_bus_addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
      if (wr) check_val({tag, "_bus_wdata"}, bus_if.bus_wdata, wd);
      check_val({tag, "_stall"}, {31'd0, hit}, 32'd0);
    end
    @(negedge clk);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0BAD_0BAD;
    #1;
    check_val({tag, "_done_hit"}, {31'd0, hit}, 32'd1);
    check_val({tag, "_done_rdata"}, rdata, exp_rdata);
    check_val({tag, "_done_req"}, {31'd0, bus_if.bus_req}, 32'd0);
  endtask

  task automatic hit_access(input string tag, input logic [31:0] a, input logic [31:0] exp_rdata);
    @(negedge clk);
    drive(1'b1, 1'b0, a, 32'd0);
    #1;
    check_val({tag, "_hit"}, {31'd0, hit}, 32'd1);
    check_val({tag, "_rdata"}, rdata, exp_rdata);
    check_val({tag, "_no_req"}, {31'd0, bus_if.bus_req}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_hit", {31'd0, hit}, 32'd1);
    check_val("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    check_val("rst_bus_addr", bus_if.bus_addr, 32'd0);
    check_val("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_hit", {31'd0, hit}, 32'd1);

    // Idle, no request
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h40, 32'd0);
    #1;
    check_val("idle_hit", {31'd0, hit}, 32'd1);
    check_val("idle_rdata", rdata, 32'd0);

    // Cold read miss, ack in second FETCH cycle, then same-cycle hit
    miss_access("rd40", 1'b1, 1'b0, 32'h40, 32'd0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    hit_access("rehit40", 32'h40, 32'hDEAD_BEEF);

    // Write hit updates the line; store DONE returns rdata=0
    miss_access("wr40", 1'b0, 1'b1, 32'h40, 32'h1234_5678, 0, 32'd0, 32'd0);
    hit_access("hit40_upd", 32'h40, 32'h1234_5678);

    // Read+write together behaves as a write (hit line updated)
    miss_access("rw40", 1'b1, 1'b1, 32'h42, 32'h5555_AAAA, 2, 32'd0, 32'd0);
    hit_access("hit40_rw", 32'h40, 32'h5555_AAAA);

    // Write miss does not allocate
    miss_access("wr80", 1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 0, 32'd0, 32'd0);
    miss_access("rd80", 1'b1, 1'b0, 32'h80, 32'd0, 0, 32'h1111_2222, 32'h1111_2222);
    hit_access("hit80", 32'h80, 32'h1111_2222);

    // Tag conflict on index 1
    miss_access("rd04", 1'b1, 1'b0, 32'h04, 32'd0, 0, 32'hAAAA_0004, 32'hAAAA_0004);
    hit_access("hit04", 32'h04, 32'hAAAA_0004);
    miss_access("rd44", 1'b1, 1'b0, 32'h44, 32'd0, 0, 32'hBBBB_0044, 32'hBBBB_0044);
    hit_access("hit44", 32'h44, 32'hBBBB_0044);
    miss_access("rd04b", 1'b1, 1'b0, 32'h04, 32'd0, 0, 32'hAAAA_0004, 32'hAAAA_0004);

    // Reset in the middle of a FETCH
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h100, 32'd0);
    #1;
    check_val("rstf_req_hit", {31'd0, hit}, 32'd0);
    @(negedge clk);
    #1;
    check_val("rstf_fetch_req", {31'd0, bus_if.bus_req}, 32'd1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    check_val("rstf_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    check_val("rstf_hit", {31'd0, hit}, 32'd1);
    rst_n = 1'b1;
    #1;
    check_val("rstf_hold_hit", {31'd0, hit}, 32'd1);

    // Valid bits cleared: previously cached 0x04 misses again
    miss_access("rd40_cold", 1'b1, 1'b0, 32'h40, 32'd0, 0, 32'h4040_4040, 32'h4040_4040);
    hit_access("h1", 32'h40, 32'h4040_4040);
    hit_access("h2", 32'h40, 32'h4040_4040);
    hit_access("h3", 32'h40, 32'h4040_4040);
    miss_access("rd100", 1'b1, 1'b0, 32'h100, 32'd0, 0, 32'h0100_0100, 32'h0100_0100);
    miss_access("rd04_cold", 1'b1, 1'b0, 32'h04, 32'd0, 0, 32'h0404_0404, 32'h0404_0404);

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check_val("stat_hits", stat_hits, 32'd3);
    check_val("stat_misses", stat_misses, 32'd3);
    force dut.stat_hits = 32'hFFFF_FFFF;
    #1;
    release dut.stat_hits;
    hit_access("sat_hit", 32'h04, 32'h0404_0404);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check_val("stat_hits_sat", stat_hits, 32'hFFFF_FFFF);
`endif

    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check_val("final_idle_hit", {31'd0, hit}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_mem_stage.md
Name: dcache_mem_stage

Overview:
- MEM-stage data-cache controller: the responder end of the EX/MEM register's `hit` stall interface.
- Consumes the EX/MEM outputs (`mem_read`, `mem_write`, `alu_result`, `read_data_2`) as a memory request.
- Returns load data and drives `hit`. `hit` high lets EX/MEM and upstream registers advance; `hit` low stalls them.
- Direct-mapped, one word per line, write-through / no-write-allocate cache in front of a req/ack backing-memory bus.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines); index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- mem_read  input  1  load request (from EX/MEM mem_read_out)
- mem_write  input  1  store request (from EX/MEM mem_write_out)
- addr  input  32  byte address (alu_result_out); addr[1:0] ignored
- wdata  input  32  store data (read_data_2_out)
- rdata  output  32  load data, valid when hit=1 on a load
- hit  output  1  access complete / no access; stage may advance
- bus_req  output  1  backing-memory request
- bus_we  output  1  1=write, 0=read; valid while bus_req=1
- bus_addr  output  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata  output  32  store data
- bus_ack  input  1  one-cycle completion from backing memory
- bus_rdata  input  32  read data, valid with bus_ack

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All valid bits clear; state=IDLE.
  - Outputs: bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0; registered rdata capture=0.
  - hit=1 during the reset cycle and the cycle after.
- FSM states: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - No request: hit=1, rdata=0.
  - Read, valid && tag match: hit=1 and rdata=line data, combinational, same cycle (0 stall cycles). Stay IDLE.
  - Read miss: hit=0; next state FETCH.
  - Write: hit=0; next state WRITE.
  - mem_read && mem_write together: treated as a write.
- FETCH:
  - bus_req=1, bus_we=0, bus_addr registered at entry.
  - Holds until bus_ack.
  - On ack: line[index] <= {valid=1, tag, bus_rdata}; rdata capture <= bus_rdata; next state DONE.
- WRITE:
  - bus_req=1, bus_we=1, bus_addr/bus_wdata registered at entry.
  - At entry, if the line is valid with matching tag, line data <= wdata (write-hit update).
  - A miss does not allocate.
  - On ack: next state DONE.
- DONE:
  - hit=1; rdata=capture for a load, 0 for a store.
  - bus_req=0; next state IDLE unconditionally.
  - A new request is evaluated in IDLE the following cycle.
- hit is combinational from state plus lookup; never asserted in FETCH/WRITE.
- bus_req drops the cycle after bus_ack, so there are no back-to-back bus requests.
- bus_ack while bus_req=0 is ignored.
- Inputs are held stable by the upstream register while hit=0; the controller latches addr/wdata at request entry regardless.
- Minimum latency:
  - Read miss: 2 stall cycles + bus latency (ack in first FETCH cycle gives hit 2 cycles after request).
  - Write: same.
- Reset mid-FETCH/WRITE: transaction abandoned; bus_req=0 the next cycle; line not written.

Optional Feature:
- Macro DCACHE_STATS_EN, when defined: adds outputs stat_hits [31:0] and stat_misses [31:0].
  - stat_hits increments on each IDLE read-hit cycle.
  - stat_misses increments on each IDLE->FETCH transition.
  - Both saturate at 32'hFFFFFFFF; both clear on reset.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then read addr 0x40: hit=0 and bus_req=1/bus_we=0/bus_addr=0x40. Ack after 2 cycles with bus_rdata=0xDEADBEEF: DONE cycle has hit=1, rdata=0xDEADBEEF. Re-read 0x40: hit=1 same cycle, no bus_req.
- Write 0x40 data 0x12345678 after fill: bus_we=1, bus_wdata=0x12345678, hit=0 until ack+1. Then read 0x40 hits with 0x12345678.
- Write miss to 0x80 (invalid line): bus write issued. Subsequent read 0x80 misses (bus_req=1, no allocate on write).
- Tag conflict (INDEX_BITS=4): fill 0x04, then read 0x44 (same index 1). Read misses and refills; re-read 0x04 misses again.
- rst_n=0 during FETCH before ack: next cycle bus_req=0, hit=1. Read of same address misses again (valid cleared).
- DCACHE_STATS_EN: 3 read hits + 2 read misses give stat_hits=3, stat_misses=2. Force stat_hits=32'hFFFFFFFF; a further hit keeps the value.
